// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin CPU/DMA access to a multi-cycle DataMemory (cpu_* MEM-stage port with stall, dma_* loader port with gnt/done pulses, mem_* memory port, busy)
module data_mem_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, we_q, we_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic cpu_win, dma_win, acc;
  always_comb begin
    cpu_win     = !reset && state_q == IDLE && cpu_req && (!dma_req || last_q);
    dma_win     = !reset && state_q == IDLE && dma_req && (!cpu_req || !last_q);
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: if (cpu_win || dma_win) begin
        state_d = ACCESS;
        owner_d = dma_win;
        last_d  = dma_win;
        we_d    = dma_win ? dma_we : cpu_we;
        addr_d  = dma_win ? dma_addr : cpu_addr;
        wdata_d = dma_win ? dma_wdata : cpu_wdata;
        cnt_d   = LAT;
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = DONE;
          cpu_rdata_d = (!we_q && !owner_q) ? mem_rdata : cpu_rdata_q;
          dma_rdata_d = (!we_q && owner_q) ? mem_rdata : dma_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end
  assign acc       = state_q == ACCESS;
  assign mem_addr  = acc ? addr_q : '0;
  assign mem_wdata = acc ? wdata_q : '0;
  assign mem_re    = acc && !we_q;
  assign mem_we    = acc && we_q && cnt_q == LAT;
  assign dma_gnt   = dma_win;
  assign dma_done  = state_q == DONE && owner_q;
  assign busy      = state_q != IDLE;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_stall = (state_q == DONE && !owner_q) ? 1'b0 : (acc && !owner_q) ? 1'b1 : cpu_req;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench for data_mem_arbiter at MEM_LATENCY=2
module tb_data_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, cpu_stall, dma_gnt, dma_done, mem_re, mem_we, busy;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  int n_cmp = 0, n_err = 0;

  data_mem_arbiter #(.MEM_LATENCY(2), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    dma_req = 1;
    #1;
    chk("rst_no_gnt", 32'(dma_gnt), 0);
    step();
    reset = 0;
    dma_req = 0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_dma_done", 32'(dma_done), 0);
    chk("rst_stall", 32'(cpu_stall), 0);

    // both requesters held: CPU wins first tie, then strict alternation
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1001_0004;
    dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0300;
    mem_rdata = 32'h1111_1111;
    for (int t = 0; t < 16; t++) begin
      #1;
      chk($sformatf("rr_gnt_t%0d", t), 32'(dma_gnt), 32'(t == 4 || t == 12));
      chk($sformatf("rr_done_t%0d", t), 32'(dma_done), 32'(t == 7 || t == 15));
      chk($sformatf("rr_addr_t%0d", t), mem_addr,
          (t == 1 || t == 2 || t == 9 || t == 10) ? 32'h1001_0004 :
          (t == 5 || t == 6 || t == 13 || t == 14) ? 32'h0000_0300 : 32'h0);
      chk($sformatf("rr_stall_t%0d", t), 32'(cpu_stall), 32'(!(t == 3 || t == 11)));
      step();
    end
    cpu_req = 0; dma_req = 0;
    #1;
    chk("rr_idle_busy", 32'(busy), 0);
    chk("rr_cpu_rdata", cpu_rdata, 32'h1111_1111);
    chk("rr_dma_rdata", dma_rdata, 32'h1111_1111);

    // CPU load, latency 2
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1001_0004; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_t0_stall", 32'(cpu_stall), 1);
    chk("ld_t0_re", 32'(mem_re), 0);
    for (int t = 1; t < 3; t++) begin
      step();
      chk($sformatf("ld_t%0d_stall", t), 32'(cpu_stall), 1);
      chk($sformatf("ld_t%0d_re", t), 32'(mem_re), 1);
      chk($sformatf("ld_t%0d_addr", t), mem_addr, 32'h1001_0004);
    end
    step();
    chk("ld_done_stall", 32'(cpu_stall), 0);
    chk("ld_done_re", 32'(mem_re), 0);
    chk("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
    step();
    cpu_req = 0;
    #1;
    chk("ld_after_busy", 32'(busy), 0);

    // CPU store: one write strobe, no read strobe, rdata untouched
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h1001_0008; cpu_wdata = 32'h0000_A5A5;
    #1;
    chk("st_t0_stall", 32'(cpu_stall), 1);
    chk("st_t0_we", 32'(mem_we), 0);
    step();
    chk("st_t1_we", 32'(mem_we), 1);
    chk("st_t1_re", 32'(mem_re), 0);
    chk("st_t1_addr", mem_addr, 32'h1001_0008);
    chk("st_t1_wdata", mem_wdata, 32'h0000_A5A5);
    step();
    chk("st_t2_we", 32'(mem_we), 0);
    chk("st_t2_re", 32'(mem_re), 0);
    chk("st_t2_addr", mem_addr, 32'h1001_0008);
    step();
    chk("st_done_stall", 32'(cpu_stall), 0);
    chk("st_done_we", 32'(mem_we), 0);
    chk("st_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    step();
    cpu_req = 0; cpu_we = 0;

    // DMA granted at t0, CPU arrives at t1 and waits
    dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0400; mem_rdata = 32'h1234_5678;
    #1;
    chk("ct_t0_gnt", 32'(dma_gnt), 1);
    step();
    dma_req = 0;
    cpu_req = 1; cpu_addr = 32'h1001_0010;
    #1;
    chk("ct_t1_stall", 32'(cpu_stall), 1);
    chk("ct_t1_addr", mem_addr, 32'h0000_0400);
    step();
    chk("ct_t2_stall", 32'(cpu_stall), 1);
    step();
    chk("ct_t3_done", 32'(dma_done), 1);
    chk("ct_t3_stall", 32'(cpu_stall), 1);
    chk("ct_t3_rdata", dma_rdata, 32'h1234_5678);
    step();
    mem_rdata = 32'hA0A0_A0A0;
    #1;
    chk("ct_t4_stall", 32'(cpu_stall), 1);
    chk("ct_t4_busy", 32'(busy), 0);
    chk("ct_t4_done", 32'(dma_done), 0);
    step();
    chk("ct_t5_addr", mem_addr, 32'h1001_0010);
    chk("ct_t5_stall", 32'(cpu_stall), 1);
    step();
    chk("ct_t6_stall", 32'(cpu_stall), 1);
    step();
    chk("ct_t7_stall", 32'(cpu_stall), 0);
    chk("ct_t7_cpu_rdata", cpu_rdata, 32'hA0A0_A0A0);
    chk("ct_t7_dma_rdata", dma_rdata, 32'h1234_5678);
    step();
    cpu_req = 0;

    // DMA write aborted by reset in its second access cycle
    dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0500; dma_wdata = 32'h0000_0077;
    #1;
    chk("ab_t0_gnt", 32'(dma_gnt), 1);
    step();
    dma_req = 0;
    #1;
    chk("ab_t1_we", 32'(mem_we), 1);
    chk("ab_t1_wdata", mem_wdata, 32'h0000_0077);
    step();
    reset = 1;
    #1;
    chk("ab_t2_we", 32'(mem_we), 0);
    step();
    reset = 0;
    #1;
    chk("ab_t3_busy", 32'(busy), 0);
    chk("ab_t3_done", 32'(dma_done), 0);
    chk("ab_t3_we", 32'(mem_we), 0);
    chk("ab_t3_cpu_rdata", cpu_rdata, 0);
    chk("ab_t3_dma_rdata", dma_rdata, 0);
    step();
    chk("ab_t4_done", 32'(dma_done), 0);
    chk("ab_t4_busy", 32'(busy), 0);

    // DMA loses the tie and withdraws before being granted
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1001_0020;
    dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0600; mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("wd_t0_gnt", 32'(dma_gnt), 0);
    step();
    dma_req = 0;
    #1;
    chk("wd_t1_addr", mem_addr, 32'h1001_0020);
    chk("wd_t1_gnt", 32'(dma_gnt), 0);
    step();
    step();
    chk("wd_t3_rdata", cpu_rdata, 32'h0BAD_F00D);
    step();
    cpu_req = 0;
    #1;
    chk("wd_t4_gnt", 32'(dma_gnt), 0);
    chk("wd_t4_busy", 32'(busy), 0);
    step();
    chk("wd_t5_busy", 32'(busy), 0);
    chk("wd_t5_addr", mem_addr, 0);
    chk("wd_t5_we", 32'(mem_we), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
